video_frame_writer: RTL and testbench

//  Captures a rectangular window of an incoming 8-bit VGA-timed grey pixel stream into a single-port

---
 rtl/video_cap_pkg.sv | 21 ++
 rtl/vid_raster_counter.sv | 71 +++++++
 rtl/video_frame_writer.sv | 141 ++++++++++++++
 tb/tb_video_frame_writer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_cap_pkg.sv
// Shared types and default window geometry for the raster capture and display paths.
package video_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned CNT_W      = 12;
    localparam int unsigned CSUM_W     = 16;

    localparam int unsigned DEF_WIN_X0 = 591;
    localparam int unsigned DEF_WIN_Y0 = 191;
    localparam int unsigned DEF_WIN_W  = 128;
    localparam int unsigned DEF_WIN_H  = 128;
    localparam int unsigned DEF_AW     = 14;

endpackage

// File: rtl/vid_raster_counter.sv
// Sync edge detection, saturating column/line counters and the capture-window flag
// for a VGA-timed pixel stream.
module vid_raster_counter
    import video_cap_pkg::*;
#(
    parameter int unsigned WIN_X0 = DEF_WIN_X0,
    parameter int unsigned WIN_Y0 = DEF_WIN_Y0,
    parameter int unsigned WIN_W  = DEF_WIN_W,
    parameter int unsigned WIN_H  = DEF_WIN_H
) (
    input  logic iClk,
    input  logic iRst_L,
    input  logic iHsync,
    input  logic iVsync,
    input  logic iDe,
    output logic oSof_c,
    output logic oInWin_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] X_LO    = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0] X_HI    = CNT_W'(WIN_X0 + WIN_W);
    localparam logic [CNT_W-1:0] Y_LO    = CNT_W'(WIN_Y0);
    localparam logic [CNT_W-1:0] Y_HI    = CNT_W'(WIN_Y0 + WIN_H);

    logic             hsyncQ;
    logic             vsyncQ;
    logic             deQ;
    logic [CNT_W-1:0] cx;
    logic [CNT_W-1:0] ly;
    logic             hsFall;

    // Syncs reset low so a reset release never looks like a falling edge.
    always_ff @(posedge iClk or negedge iRst_L) begin
        if (!iRst_L) begin
            hsyncQ <= 1'b0;
            vsyncQ <= 1'b0;
            deQ    <= 1'b0;
        end else begin
            hsyncQ <= iHsync;
            vsyncQ <= iVsync;
            deQ    <= iDe;
        end
    end

    assign hsFall = hsyncQ & ~iHsync;
    assign oSof_c = vsyncQ & ~iVsync;

    // cx counts qualified pixels already seen in this line; ly counts completed active lines.
    always_ff @(posedge iClk or negedge iRst_L) begin
        if (!iRst_L) begin
            cx <= '0;
            ly <= '0;
        end else begin
            if (hsFall) begin
                cx <= '0;
            end else if (iDe && (cx != CNT_MAX)) begin
                cx <= cx + CNT_W'(1);
            end

            if (oSof_c) begin
                ly <= '0;
            end else if (deQ && !iDe && (ly != CNT_MAX)) begin
                ly <= ly + CNT_W'(1);
            end
        end
    end

    assign oInWin_c = iDe && (cx >= X_LO) && (cx < X_HI) && (ly >= Y_LO) && (ly < Y_HI);

endmodule

// File: rtl/video_frame_writer.sv
// Captures one window of a raster pixel stream into image RAM per iArm.
// Optional CAPTURE_CHECKSUM_EN adds a 16-bit sum of the captured pixels.
module video_frame_writer
    import video_cap_pkg::*;
#(
    parameter int unsigned WIN_X0 = DEF_WIN_X0,
    parameter int unsigned WIN_Y0 = DEF_WIN_Y0,
    parameter int unsigned WIN_W  = DEF_WIN_W,
    parameter int unsigned WIN_H  = DEF_WIN_H,
    parameter int unsigned AW     = DEF_AW
) (
    input  logic             iClk,
    input  logic             iRst_L,
    input  logic             iArm,
    input  logic             iHsync,
    input  logic             iVsync,
    input  logic             iDe,
    input  logic [PIX_W-1:0] iPixel,
    output logic [AW-1:0]    oWrAddr,
    output logic [PIX_W-1:0] oWrData,
    output logic             oWrEn,
    output logic             oBusy,
    output logic             oDone,
    output logic             oShort
`ifdef CAPTURE_CHECKSUM_EN
    ,
    output logic [CSUM_W-1:0] oChecksum
`endif
);

    localparam int unsigned   NPIX      = WIN_W * WIN_H;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    cap_state_t       state;
    cap_state_t       stateNext;
    logic [AW-1:0]    addrCnt;
    logic [AW-1:0]    addrNext;
    logic [AW-1:0]    wrAddrNext;
    logic [PIX_W-1:0] wrDataNext;
    logic             wrEnNext;
    logic             busyNext;
    logic             doneNext;
    logic             shortNext;
    logic             sof;
    logic             inWin;

    vid_raster_counter #(
        .WIN_X0 (WIN_X0),
        .WIN_Y0 (WIN_Y0),
        .WIN_W  (WIN_W),
        .WIN_H  (WIN_H)
    ) uRaster (
        .iClk     (iClk),
        .iRst_L   (iRst_L),
        .iHsync   (iHsync),
        .iVsync   (iVsync),
        .iDe      (iDe),
        .oSof_c   (sof),
        .oInWin_c (inWin)
    );

    always_ff @(posedge iClk or negedge iRst_L) begin
        if (!iRst_L) begin
            state   <= IDLE;
            addrCnt <= '0;
            oWrEn   <= 1'b0;
            oWrAddr <= '0;
            oWrData <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oShort  <= 1'b0;
        end else begin
            state   <= stateNext;
            addrCnt <= addrNext;
            oWrEn   <= wrEnNext;
            oWrAddr <= wrAddrNext;
            oWrData <= wrDataNext;
            oBusy   <= busyNext;
            oDone   <= doneNext;
            oShort  <= shortNext;
        end
    end

    // SOF outranks a pixel in the same cycle; an arm coinciding with SOF waits for the next one.
    always_comb begin
        stateNext  = state;
        addrNext   = addrCnt;
        wrEnNext   = 1'b0;
        wrAddrNext = oWrAddr;
        wrDataNext = oWrData;
        doneNext   = oDone;
        shortNext  = oShort;
        case (state)
            IDLE, DONE: begin
                if (iArm) begin
                    stateNext = WAIT_VS;
                    doneNext  = 1'b0;
                    shortNext = 1'b0;
                end
            end
            WAIT_VS: begin
                if (sof) begin
                    stateNext = CAPTURE;
                    addrNext  = '0;
                end
            end
            CAPTURE: begin
                if (sof) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                    shortNext = 1'b1;
                end else if (inWin) begin
                    wrEnNext   = 1'b1;
                    wrAddrNext = addrCnt;
                    wrDataNext = iPixel;
                    addrNext   = addrCnt + AW'(1);
                    if (addrCnt == LAST_ADDR) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext == WAIT_VS) || (stateNext == CAPTURE);
    end

`ifdef CAPTURE_CHECKSUM_EN
    // Running sum restarts when a capture begins and follows every write strobe.
    always_ff @(posedge iClk or negedge iRst_L) begin
        if (!iRst_L) begin
            oChecksum <= '0;
        end else if ((state == WAIT_VS) && sof) begin
            oChecksum <= '0;
        end else if (wrEnNext) begin
            oChecksum <= oChecksum + CSUM_W'(iPixel);
        end
    end
`endif

endmodule

// File: tb/tb_video_frame_writer.sv
// Self-checking bench for video_frame_writer using a reduced window and short raster timing.
// Expected writes come from a (line, column) pixel model of each generated frame.
module tb_video_frame_writer;

    localparam int X0    = 37;
    localparam int Y0    = 11;
    localparam int W     = 16;
    localparam int H     = 8;
    localparam int AW    = 7;
    localparam int NPIX  = W * H;
    localparam int ACT_W = 60;
    localparam int ACT_H = 24;
    localparam int VBP   = 2;
    localparam int VFP   = 1;

    logic          iClk   = 1'b0;
    logic          iRst_L = 1'b0;
    logic          iArm   = 1'b0;
    logic          iHsync = 1'b1;
    logic          iVsync = 1'b1;
    logic          iDe    = 1'b0;
    logic [7:0]    iPixel = 8'h00;
    logic [AW-1:0] oWrAddr;
    logic [7:0]    oWrData;
    logic          oWrEn;
    logic          oBusy;
    logic          oDone;
    logic          oShort;
`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0]   oChecksum;
`endif

    int nChecks = 0;
    int nFail   = 0;
    int doneRises = 0;
    logic doneQ = 1'b0;
    int expSum = 0;

    logic [AW-1:0] gotAddr[$];
    logic [7:0]    gotData[$];
    logic [AW-1:0] expAddr[$];
    logic [7:0]    expData[$];

    video_frame_writer #(
        .WIN_X0 (X0),
        .WIN_Y0 (Y0),
        .WIN_W  (W),
        .WIN_H  (H),
        .AW     (AW)
    ) dut (
        .iClk    (iClk),
        .iRst_L  (iRst_L),
        .iArm    (iArm),
        .iHsync  (iHsync),
        .iVsync  (iVsync),
        .iDe     (iDe),
        .iPixel  (iPixel),
        .oWrAddr (oWrAddr),
        .oWrData (oWrData),
        .oWrEn   (oWrEn),
        .oBusy   (oBusy),
        .oDone   (oDone),
`ifdef CAPTURE_CHECKSUM_EN
        .oShort    (oShort),
        .oChecksum (oChecksum)
`else
        .oShort  (oShort)
`endif
    );

    always #5 iClk = ~iClk;

    // Write collector and oDone rise counter, sampled away from the active edge.
    always @(negedge iClk) begin
        if (iRst_L && oWrEn) begin
            gotAddr.push_back(oWrAddr);
            gotData.push_back(oWrData);
        end
        doneQ <= oDone;
        if (iRst_L && oDone && !doneQ) doneRises <= doneRises + 1;
    end

    task automatic step(input logic hs, input logic vs, input logic de,
                        input logic [7:0] px, input logic arm);
        @(negedge iClk);
        iHsync = hs;
        iVsync = vs;
        iDe    = de;
        iPixel = px;
        iArm   = arm;
    endtask

    task automatic arm_pulse();
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic vsync_pulse();
        repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Drives one frame starting at a vsync fall and checks the write stream it produced.
    // mode: 0 random, 1 (col+line)&FF, 2 constant 3. cap says whether this frame should be captured.
    task automatic drive_frame(input string name, input int nLines, input int mode, input bit cap,
                               input int armLine, input bit armAtSof);
        int ly;
        int nBad;
        int n;
        logic [7:0] px;
        gotAddr.delete(); gotData.delete();
        expAddr.delete(); expData.delete();
        expSum = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00, armAtSof);
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int l = 0; l < VBP + nLines + VFP; l++) begin
            repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            if (l >= VBP && l < VBP + nLines) begin
                ly = l - VBP;
                for (int c = 0; c < ACT_W; c++) begin
                    case (mode)
                        0:       px = 8'($urandom);
                        1:       px = 8'(c + ly);
                        default: px = 8'h03;
                    endcase
                    if (cap && ly >= Y0 && ly < Y0 + H && c >= X0 && c < X0 + W) begin
                        expAddr.push_back(AW'((ly - Y0) * W + (c - X0)));
                        expData.push_back(px);
                        expSum = (expSum + int'(px)) % 65536;
                    end
                    step(1'b1, 1'b1, 1'b1, px, (ly == armLine) && (c == ACT_W / 2));
                end
            end else begin
                repeat (ACT_W) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            end
            repeat (2) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        nChecks++;
        if (gotAddr.size() !== expAddr.size()) begin
            nFail++;
            $display("FAIL %s write_count got=%0d exp=%0d", name, gotAddr.size(), expAddr.size());
        end
        n = (gotAddr.size() < expAddr.size()) ? gotAddr.size() : expAddr.size();
        nBad = 0;
        for (int i = 0; i < n && nBad < 4; i++) begin
            nChecks++;
            if (gotAddr[i] !== expAddr[i] || gotData[i] !== expData[i]) begin
                nFail++;
                nBad++;
                $display("FAIL %s write[%0d] got addr=%0d data=%02h exp addr=%0d data=%02h",
                         name, i, gotAddr[i], gotData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_reset();
        iRst_L = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i[0], 8'hFF, 1'b1);
        nChecks++;
        if ({oWrEn, oWrAddr, oWrData, oBusy, oDone, oShort} !== '0) begin
            nFail++;
            $display("FAIL reset_outputs got en=%b addr=%0d data=%02h busy=%b done=%b short=%b exp all 0",
                     oWrEn, oWrAddr, oWrData, oBusy, oDone, oShort);
        end
        @(negedge iClk);
        iArm = 1'b0; iDe = 1'b0; iPixel = 8'h00; iRst_L = 1'b1;
        drive_frame("reset_noarm", ACT_H, 0, 1'b0, -1, 1'b0);
        nChecks++;
        if (oBusy !== 1'b0 || oDone !== 1'b0) begin
            nFail++;
            $display("FAIL reset_idle got busy=%b done=%b exp 0 0", oBusy, oDone);
        end
    endtask

    task automatic test_full_frame();
        arm_pulse();
        nChecks++;
        if (oBusy !== 1'b1) begin
            nFail++;
            $display("FAIL full_busy got=%b exp=1", oBusy);
        end
        drive_frame("full", ACT_H, 1, 1'b1, -1, 1'b0);
        nChecks++;
        if (gotAddr.size() == 0 || gotAddr[0] !== AW'(0) || gotData[0] !== 8'(X0 + Y0)) begin
            nFail++;
            $display("FAIL full_first got size=%0d exp addr=0 data=%02h", gotAddr.size(), 8'(X0 + Y0));
        end
        nChecks++;
        if (gotAddr.size() == 0 || gotAddr[gotAddr.size() - 1] !== AW'(NPIX - 1)) begin
            nFail++;
            $display("FAIL full_last got size=%0d exp last addr=%0d", gotAddr.size(), NPIX - 1);
        end
        nChecks++;
        if (oDone !== 1'b1 || oShort !== 1'b0 || oBusy !== 1'b0) begin
            nFail++;
            $display("FAIL full_status got done=%b short=%b busy=%b exp 1 0 0", oDone, oShort, oBusy);
        end
`ifdef CAPTURE_CHECKSUM_EN
        nChecks++;
        if (oChecksum !== 16'(expSum)) begin
            nFail++;
            $display("FAIL full_checksum got=%04h exp=%04h", oChecksum, 16'(expSum));
        end
`endif
    endtask

    task automatic test_arm_mid_frame();
        drive_frame("mid_arm_frame", ACT_H, 0, 1'b0, 2, 1'b0);
        nChecks++;
        if (oBusy !== 1'b1 || oDone !== 1'b0 || oShort !== 1'b0) begin
            nFail++;
            $display("FAIL mid_arm_status got busy=%b done=%b short=%b exp 1 0 0", oBusy, oDone, oShort);
        end
        drive_frame("mid_arm_next", ACT_H, 0, 1'b1, -1, 1'b0);
        nChecks++;
        if (oDone !== 1'b1 || oShort !== 1'b0) begin
            nFail++;
            $display("FAIL mid_arm_done got done=%b short=%b exp 1 0", oDone, oShort);
        end
    endtask

    task automatic test_short_frame();
        int hLines;
        hLines = 4;
        arm_pulse();
        drive_frame("short", Y0 + hLines, 0, 1'b1, -1, 1'b0);
        nChecks++;
        if (gotAddr.size() == 0 || gotAddr[gotAddr.size() - 1] !== AW'(hLines * W - 1)) begin
            nFail++;
            $display("FAIL short_last got size=%0d exp last addr=%0d", gotAddr.size(), hLines * W - 1);
        end
        nChecks++;
        if (oDone !== 1'b0 || oBusy !== 1'b1) begin
            nFail++;
            $display("FAIL short_pending got done=%b busy=%b exp 0 1", oDone, oBusy);
        end
        gotAddr.delete(); gotData.delete();
        vsync_pulse();
        nChecks++;
        if (gotAddr.size() != 0 || oDone !== 1'b1 || oShort !== 1'b1 || oBusy !== 1'b0) begin
            nFail++;
            $display("FAIL short_status got writes=%0d done=%b short=%b busy=%b exp 0 1 1 0",
                     gotAddr.size(), oDone, oShort, oBusy);
        end
`ifdef CAPTURE_CHECKSUM_EN
        nChecks++;
        if (oChecksum !== 16'(expSum)) begin
            nFail++;
            $display("FAIL short_checksum got=%04h exp=%04h", oChecksum, 16'(expSum));
        end
`endif
    endtask

    task automatic test_arm_during_capture();
        int r0;
        arm_pulse();
        r0 = doneRises;
        drive_frame("arm_in_capture", ACT_H, 0, 1'b1, Y0 + 2, 1'b0);
        nChecks++;
        if (doneRises - r0 != 1 || oDone !== 1'b1 || oShort !== 1'b0) begin
            nFail++;
            $display("FAIL arm_in_capture_done got rises=%0d done=%b short=%b exp 1 1 0",
                     doneRises - r0, oDone, oShort);
        end
        drive_frame("after_done_noarm", ACT_H, 0, 1'b0, -1, 1'b0);
        nChecks++;
        if (doneRises - r0 != 1 || oDone !== 1'b1) begin
            nFail++;
            $display("FAIL after_done_hold got rises=%0d done=%b exp 1 1", doneRises - r0, oDone);
        end
    endtask

    task automatic test_arm_on_sof();
        drive_frame("arm_on_sof", ACT_H, 0, 1'b0, -1, 1'b1);
        nChecks++;
        if (oBusy !== 1'b1 || oDone !== 1'b0) begin
            nFail++;
            $display("FAIL arm_on_sof_wait got busy=%b done=%b exp 1 0", oBusy, oDone);
        end
        drive_frame("const3", ACT_H, 2, 1'b1, -1, 1'b0);
        nChecks++;
        if (oDone !== 1'b1 || oShort !== 1'b0) begin
            nFail++;
            $display("FAIL const3_done got done=%b short=%b exp 1 0", oDone, oShort);
        end
`ifdef CAPTURE_CHECKSUM_EN
        nChecks++;
        if (oChecksum !== 16'((NPIX * 3) % 65536)) begin
            nFail++;
            $display("FAIL const3_checksum got=%04h exp=%04h", oChecksum, 16'((NPIX * 3) % 65536));
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            arm_pulse();
            drive_frame("b2b", ACT_H, 0, 1'b1, -1, 1'b0);
            nChecks++;
            if (oDone !== 1'b1 || oShort !== 1'b0) begin
                nFail++;
                $display("FAIL b2b_done[%0d] got done=%b short=%b exp 1 0", k, oDone, oShort);
            end
`ifdef CAPTURE_CHECKSUM_EN
            nChecks++;
            if (oChecksum !== 16'(expSum)) begin
                nFail++;
                $display("FAIL b2b_checksum[%0d] got=%04h exp=%04h", k, oChecksum, 16'(expSum));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_arm_mid_frame();
        test_short_frame();
        test_arm_during_capture();
        test_arm_on_sof();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
